// File: rtl/result_stream_tx.sv
// Drains DEPTH result words from the result RAM and streams them LS byte first on a valid/ready byte port.
// Optional RESULT_TX_CHECKSUM_EN appends an XOR checksum byte that carries tx_last.
module result_stream_tx #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              done
);

  localparam int BYTES = DATA_W / 8;
  localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_CAPT,
    S_SEND,
`ifdef RESULT_TX_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE
  } state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [BC_W-1:0]   r_byte_cnt;
  logic [DATA_W-1:0] r_hold;
`ifdef RESULT_TX_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic w_accept, w_last_byte, w_last_word;

  assign w_accept    = (r_state == S_SEND) && tx_ready;
  assign w_last_byte = (r_byte_cnt == LAST_BYTE);
  assign w_last_word = (r_word_cnt == LAST_WORD);

  // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // NOTE: every output and next-state term gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    w_next   = r_state;
    ram_rd   = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_REQ;
      S_REQ: begin
        ram_rd = 1'b1;
        w_next = S_CAPT;
      end
      S_CAPT: w_next = S_SEND;
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = r_hold[7:0];
`ifndef RESULT_TX_CHECKSUM_EN
        tx_last  = w_last_byte && w_last_word;
`endif
        if (w_accept && w_last_byte) begin
`ifdef RESULT_TX_CHECKSUM_EN
          w_next = w_last_word ? S_CSUM : S_REQ;
`else
          w_next = w_last_word ? S_DONE : S_REQ;
`endif
        end
      end
`ifdef RESULT_TX_CHECKSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = r_csum;
        tx_last  = 1'b1;
        if (tx_ready) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign ram_addr = r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_word_cnt <= '0;
      r_byte_cnt <= '0;
      r_hold     <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_word_cnt <= '0;
`ifdef RESULT_TX_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
        S_CAPT: begin
          r_hold     <= ram_rdata;
          r_byte_cnt <= '0;
        end
        S_SEND: if (w_accept) begin
          r_hold     <= r_hold >> 8;
          r_byte_cnt <= r_byte_cnt + BC_W'(1);
`ifdef RESULT_TX_CHECKSUM_EN
          r_csum     <= r_csum ^ r_hold[7:0];
`endif
          // The counter stops at the last word so ram_addr never leaves 0..DEPTH-1.
          if (w_last_byte && !w_last_word) r_word_cnt <= r_word_cnt + ADDR_W'(1);
        end
        S_DONE: r_word_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_result_stream_tx.sv
// Self-checking bench for result_stream_tx: RAM responder, stream monitor and a byte-list reference model.
module tb_result_stream_tx;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;
`ifdef RESULT_TX_CHECKSUM_EN
  localparam int EXP_CYC = DEPTH * (2 + BYTES) + 2;
`else
  localparam int EXP_CYC = DEPTH * (2 + BYTES) + 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              tx_ready = 1'b0;
  logic              ram_rd, tx_valid, tx_last, busy, done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [7:0]        tx_data;

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [7:0] got_q[$];
  bit         last_q[$];
  int         addr_q[$];
  int         done_cnt = 0;

  always #5 clk = ~clk;

  result_stream_tx #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_rd(ram_rd), .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done)
  );

  // Synchronous-read RAM; outside a read the data bus carries random junk.
  always @(posedge clk) ram_rdata <= ram_rd ? ram[ram_addr] : DATA_W'($urandom);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream monitor: collects accepted bytes, read addresses, done pulses; checks stall stability.
  bit         p_stall = 1'b0;
  logic [7:0] p_data;
  logic       p_last;
  always @(negedge clk) begin
    if (rst) begin
      if (p_stall) begin
        check("stall_valid", tx_valid, 1);
        check("stall_data", tx_data, p_data);
        check("stall_last", tx_last, p_last);
      end
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        last_q.push_back(tx_last);
      end
      if (ram_rd) addr_q.push_back(int'(ram_addr));
      if (done) done_cnt++;
    end
    p_stall = rst && tx_valid && !tx_ready;
    p_data  = tx_data;
    p_last  = tx_last;
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Reference: the transfer is simply every RAM word split LS byte first, plus an optional XOR byte.
  task automatic compare_stream(input string name);
    logic [7:0] exp_q[$];
    logic [7:0] x = 8'h00;
    int n;
    for (int w = 0; w < DEPTH; w++)
      for (int b = 0; b < BYTES; b++) begin
        exp_q.push_back(8'((ram[w] >> (8 * b)) & 'hFF));
        x ^= 8'((ram[w] >> (8 * b)) & 'hFF);
      end
`ifdef RESULT_TX_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s_last%0d", name, i), last_q[i], i == exp_q.size() - 1);
    end
    check({name, "_nreads"}, addr_q.size(), DEPTH);
    for (int i = 0; i < addr_q.size() && i < DEPTH; i++)
      check($sformatf("%s_addr%0d", name, i), addr_q[i], i);
  endtask

  task automatic clear_logs();
    got_q.delete();
    last_q.delete();
    addr_q.delete();
    done_cnt = 0;
  endtask

  // Called just after a posedge (+#1); pulses start and runs until done or a cycle budget expires.
  task automatic run_xfer(input string name, input int mode, input int restart_at, input bit chk_cyc);
    int cyc = 0;
    bit seen = 1'b0;
    clear_logs();
    start    = 1'b1;
    tx_ready = ready_for(mode, 0);
    while (!seen && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      start    = (cyc == restart_at);
      tx_ready = ready_for(mode, cyc);
      if (done) seen = 1'b1;
    end
    check({name, "_done_seen"}, seen, 1);
    if (chk_cyc) check({name, "_cycles"}, cyc, EXP_CYC);
    @(posedge clk); #1;
    check({name, "_busy_after"}, busy, 0);
    check({name, "_done_after"}, done, 0);
    repeat (2) @(posedge clk);
    #1;
    check({name, "_done_pulses"}, done_cnt, 1);
    compare_stream(name);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ram_rd"}, ram_rd, 0);
    check({name, "_ram_addr"}, ram_addr, 0);
    check({name, "_tx_valid"}, tx_valid, 0);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_tx_last"}, tx_last, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
  endtask

  initial begin
    int cyc;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic drain with the counting pattern.
    for (int k = 0; k < DEPTH; k++) ram[k] = 32'h0000_0100 * k + k;
    run_xfer("basic", 0, 0, 1'b1);

    // Backpressure with a 1,0,0 ready pattern.
    ram[0] = 32'hDEAD_BEEF;
    for (int k = 1; k < DEPTH; k++) ram[k] = $urandom;
    run_xfer("bp", 1, 0, 1'b0);
    if (got_q.size() >= 4) begin
      check("bp_b0", got_q[0], 8'hEF);
      check("bp_b1", got_q[1], 8'hBE);
      check("bp_b2", got_q[2], 8'hAD);
      check("bp_b3", got_q[3], 8'hDE);
    end else check("bp_short", got_q.size(), 4);

    // Second start during a transfer is ignored.
    for (int k = 0; k < DEPTH; k++) ram[k] = $urandom;
    run_xfer("restart", 0, 10, 1'b1);

    // Reset while word 3 byte 2 is on the bus.
    clear_logs();
    start    = 1'b1;
    tx_ready = 1'b1;
    cyc      = 0;
    while (cyc < 6 * 3 + 3 + 2) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
    end
    check("abort_valid", tx_valid, 1);
    check("abort_byte", tx_data, 8'((ram[3] >> 16) & 'hFF));
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    rst = 1'b1;
    check("abort_no_done", done_cnt, 0);
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) ram[k] = $urandom;
    run_xfer("after_abort", 0, 0, 1'b1);

    // Random words against random backpressure.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) ram[k] = $urandom;
      run_xfer($sformatf("rand%0d", r), 2, 0, 1'b0);
    end

`ifdef RESULT_TX_CHECKSUM_EN
    for (int k = 0; k < DEPTH; k++) ram[k] = 32'h0102_0304;
    run_xfer("csum_a", 0, 0, 1'b1);
    if (got_q.size() == DEPTH * BYTES + 1) check("csum_a_val", got_q[DEPTH * BYTES], 8'h00);
    ram[0] = 32'h0000_0001;
    run_xfer("csum_b", 1, 0, 1'b0);
    if (got_q.size() == DEPTH * BYTES + 1) check("csum_b_val", got_q[DEPTH * BYTES], 8'h05);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
